// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: bypass selects, ALU opcodes,
// default widths and the EXE-stage bubble control vector.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_RN_W  = 5;

  localparam logic [1:0] FWD_RF     = 2'b00;
  localparam logic [1:0] FWD_EXE    = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       jal;
    logic       valid;
    logic [3:0] aluc;
  } ex_ctrl_t;

  // A bubble has no side effects and decodes as ADD.
  localparam ex_ctrl_t BUBBLE_CTRL = '{
    wreg:  1'b0,
    m2reg: 1'b0,
    wmem:  1'b0,
    jal:   1'b0,
    valid: 1'b0,
    aluc:  ALU_ADD
  };

endpackage

// File: rtl/operand_fwd_mux.sv
// 4:1 bypass mux for one ALU source operand.
// Ports: sel, rf, e_alu, m_alu, m_mem -> y.
module operand_fwd_mux
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] rf,
  input  logic [WIDTH-1:0] e_alu,
  input  logic [WIDTH-1:0] m_alu,
  input  logic [WIDTH-1:0] m_mem,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = rf;
    unique case (sel)
      FWD_RF:     y = rf;
      FWD_EXE:    y = e_alu;
      FWD_MEMALU: y = m_alu;
      FWD_MEMLD:  y = m_mem;
      default:    y = rf;
    endcase
  end

endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with rs/rt bypass, stall and flush.
// Ports: clock, reset, stall, flush, d_* ID fields -> e_* EXE fields.
module id_exe_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RN_W  = DEF_RN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d_qa,
  input  logic [WIDTH-1:0] d_qb,
  input  logic [1:0]       d_fwda,
  input  logic [1:0]       d_fwdb,
  input  logic [WIDTH-1:0] e_alu_fb,
  input  logic [WIDTH-1:0] m_alu_fb,
  input  logic [WIDTH-1:0] m_mem_fb,
  input  logic [WIDTH-1:0] d_imm,
  input  logic [4:0]       d_sa,
  input  logic [3:0]       d_aluc,
  input  logic             d_aluimm,
  input  logic             d_shift,
  input  logic             d_wreg,
  input  logic             d_m2reg,
  input  logic             d_wmem,
  input  logic             d_jal,
  input  logic [RN_W-1:0]  d_rn,
  input  logic [WIDTH-1:0] d_pc4,
  output logic [WIDTH-1:0] e_a,
  output logic [WIDTH-1:0] e_b,
  output logic [3:0]       e_aluc,
  output logic [WIDTH-1:0] e_st_data,
  output logic             e_wreg,
  output logic             e_m2reg,
  output logic             e_wmem,
  output logic             e_jal,
  output logic [RN_W-1:0]  e_rn,
  output logic [WIDTH-1:0] e_pc8,
  output logic             e_valid
);

  logic [WIDTH-1:0] fa;
  logic [WIDTH-1:0] fb;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  ex_ctrl_t         ctrl_q;
  ex_ctrl_t         ctrl_d;

  operand_fwd_mux #(.WIDTH(WIDTH)) u_fwd_a (
    .sel   (d_fwda),
    .rf    (d_qa),
    .e_alu (e_alu_fb),
    .m_alu (m_alu_fb),
    .m_mem (m_mem_fb),
    .y     (fa)
  );

  operand_fwd_mux #(.WIDTH(WIDTH)) u_fwd_b (
    .sel   (d_fwdb),
    .rf    (d_qb),
    .e_alu (e_alu_fb),
    .m_alu (m_alu_fb),
    .m_mem (m_mem_fb),
    .y     (fb)
  );

  // Shifts take the amount on operand a and shift operand b.
  assign a_nxt = d_shift
    ? {{(WIDTH-5){1'b0}}, d_sa}
    : fa;
  assign b_nxt = d_aluimm ? d_imm : fb;

  assign ctrl_d = '{
    wreg:  d_wreg,
    m2reg: d_m2reg,
    wmem:  d_wmem,
    jal:   d_jal,
    valid: 1'b1,
    aluc:  d_aluc
  };

  // Flush outranks stall so a squashed slot keeps no side effects.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      ctrl_q    <= BUBBLE_CTRL;
      e_a       <= '0;
      e_b       <= '0;
      e_st_data <= '0;
      e_rn      <= '0;
      e_pc8     <= '0;
    end else if (!stall) begin
      ctrl_q    <= ctrl_d;
      e_a       <= a_nxt;
      e_b       <= b_nxt;
      e_st_data <= fb;
      e_rn      <= d_rn;
      e_pc8     <= d_pc4 + WIDTH'(4);
    end
  end

  assign e_wreg  = ctrl_q.wreg;
  assign e_m2reg = ctrl_q.m2reg;
  assign e_wmem  = ctrl_q.wmem;
  assign e_jal   = ctrl_q.jal;
  assign e_valid = ctrl_q.valid;
  assign e_aluc  = ctrl_q.aluc;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: directed vectors with
// literal checks plus a per-cycle compare against a spec model.
module tb_id_exe_reg;

  logic        clock = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] d_qa, d_qb, e_alu_fb, m_alu_fb, m_mem_fb;
  logic [1:0]  d_fwda, d_fwdb;
  logic [31:0] d_imm, d_pc4;
  logic [4:0]  d_sa, d_rn;
  logic [3:0]  d_aluc;
  logic        d_aluimm, d_shift, d_wreg, d_m2reg, d_wmem, d_jal;
  logic [31:0] e_a, e_b, e_st_data, e_pc8;
  logic [3:0]  e_aluc;
  logic [4:0]  e_rn;
  logic        e_wreg, e_m2reg, e_wmem, e_jal, e_valid;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  always #5 clock = ~clock;

  id_exe_reg dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .d_qa(d_qa), .d_qb(d_qb), .d_fwda(d_fwda), .d_fwdb(d_fwdb),
    .e_alu_fb(e_alu_fb), .m_alu_fb(m_alu_fb), .m_mem_fb(m_mem_fb),
    .d_imm(d_imm), .d_sa(d_sa), .d_aluc(d_aluc),
    .d_aluimm(d_aluimm), .d_shift(d_shift), .d_wreg(d_wreg),
    .d_m2reg(d_m2reg), .d_wmem(d_wmem), .d_jal(d_jal),
    .d_rn(d_rn), .d_pc4(d_pc4),
    .e_a(e_a), .e_b(e_b), .e_aluc(e_aluc), .e_st_data(e_st_data),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_wmem(e_wmem),
    .e_jal(e_jal), .e_rn(e_rn), .e_pc8(e_pc8), .e_valid(e_valid)
  );

  // Spec model: what EXE must hold after each edge.
  logic [31:0] x_a, x_b, x_st, x_pc8;
  logic [3:0]  x_aluc;
  logic [4:0]  x_rn;
  logic        x_wreg, x_m2reg, x_wmem, x_jal, x_valid;

  always @(posedge clock) begin
    logic [31:0] src [4];
    src[0] = d_qa;
    src[1] = e_alu_fb;
    src[2] = m_alu_fb;
    src[3] = m_mem_fb;
    if (reset || flush) begin
      {x_a, x_b, x_st, x_pc8} <= '0;
      {x_aluc, x_rn} <= '0;
      {x_wreg, x_m2reg, x_wmem, x_jal, x_valid} <= '0;
    end else if (!stall) begin
      x_a <= d_shift ? 32'(d_sa) : src[d_fwda];
      src[0] = d_qb;
      x_b <= d_aluimm ? d_imm : src[d_fwdb];
      x_st <= src[d_fwdb];
      x_pc8 <= 32'((64'(d_pc4) + 64'd4) % 64'h1_0000_0000);
      x_aluc <= d_aluc;
      x_rn <= d_rn;
      x_wreg <= d_wreg;
      x_m2reg <= d_m2reg;
      x_wmem <= d_wmem;
      x_jal <= d_jal;
      x_valid <= 1'b1;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (checking) begin
      chk("m_a", e_a, x_a);
      chk("m_b", e_b, x_b);
      chk("m_st", e_st_data, x_st);
      chk("m_pc8", e_pc8, x_pc8);
      chk("m_aluc", 32'(e_aluc), 32'(x_aluc));
      chk("m_rn", 32'(e_rn), 32'(x_rn));
      chk("m_ctrl",
          32'({e_wreg, e_m2reg, e_wmem, e_jal, e_valid}),
          32'({x_wreg, x_m2reg, x_wmem, x_jal, x_valid}));
    end
  end

  task automatic rand_id();
    d_qa = $urandom; d_qb = $urandom;
    e_alu_fb = $urandom; m_alu_fb = $urandom; m_mem_fb = $urandom;
    d_fwda = 2'($urandom); d_fwdb = 2'($urandom);
    d_imm = $urandom; d_pc4 = $urandom;
    d_sa = 5'($urandom); d_rn = 5'($urandom);
    d_aluc = 4'($urandom);
    d_aluimm = 1'($urandom); d_shift = 1'($urandom);
    d_wreg = 1'($urandom); d_m2reg = 1'($urandom);
    d_wmem = 1'($urandom); d_jal = 1'($urandom);
  endtask

  task automatic nop_id();
    d_qa = '0; d_qb = '0; e_alu_fb = '0; m_alu_fb = '0;
    m_mem_fb = '0; d_fwda = '0; d_fwdb = '0; d_imm = '0;
    d_pc4 = '0; d_sa = '0; d_rn = '0; d_aluc = '0;
    d_aluimm = 0; d_shift = 0; d_wreg = 0; d_m2reg = 0;
    d_wmem = 0; d_jal = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1; stall = 0; flush = 0;
    rand_id();
    tick();
    checking = 1'b1;
    rand_id();
    tick();
    chk("rst_valid", 32'(e_valid), 0);
    chk("rst_a", e_a, 0);
    chk("rst_aluc", 32'(e_aluc), 0);
    chk("rst_wreg", 32'(e_wreg), 0);

    reset = 0;
    nop_id(); d_qa = 5; d_qb = 7;
    tick();
    chk("first_a", e_a, 5);
    chk("first_b", e_b, 7);
    chk("first_valid", 32'(e_valid), 1);

    nop_id();
    d_qa = 1; d_fwda = 2'b01; e_alu_fb = 32'h10;
    d_qb = 2; d_fwdb = 2'b11; m_mem_fb = 32'hDEAD;
    tick();
    chk("byp_a", e_a, 32'h10);
    chk("byp_b", e_b, 32'hDEAD);
    chk("byp_st", e_st_data, 32'hDEAD);

    d_fwda = 2'b10; d_fwdb = 2'b10; m_alu_fb = 32'h33;
    tick();
    chk("byp_ma", e_a, 32'h33);
    chk("byp_mb", e_b, 32'h33);

    nop_id();
    d_aluimm = 1; d_imm = 32'hFFFF_FFFC; d_qb = 9;
    tick();
    chk("imm_b", e_b, 32'hFFFF_FFFC);
    chk("imm_st", e_st_data, 9);

    nop_id();
    d_shift = 1; d_sa = 31; d_aluc = 4'b1111; d_qa = 32'h1234;
    tick();
    chk("sh_a", e_a, 32'h1F);
    chk("sh_aluc", 32'(e_aluc), 32'hF);

    nop_id(); d_qa = 32'hAA; d_wreg = 1;
    tick();
    chk("pre_stall_a", e_a, 32'hAA);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      chk("stall_a", e_a, 32'hAA);
      chk("stall_wreg", 32'(e_wreg), 1);
    end
    stall = 0;
    nop_id(); d_qa = 32'h55;
    tick();
    chk("unstall_a", e_a, 32'h55);

    nop_id();
    stall = 1; flush = 1; d_wreg = 1; d_wmem = 1; d_aluc = 4'h5;
    tick();
    chk("fl_wreg", 32'(e_wreg), 0);
    chk("fl_wmem", 32'(e_wmem), 0);
    chk("fl_valid", 32'(e_valid), 0);
    chk("fl_aluc", 32'(e_aluc), 0);
    flush = 0;
    tick();
    chk("fl_hold_valid", 32'(e_valid), 0);

    stall = 0;
    nop_id(); d_pc4 = 32'hFFFF_FFFC; d_jal = 1;
    tick();
    chk("wrap_pc8", e_pc8, 0);
    chk("wrap_jal", 32'(e_jal), 1);
    d_pc4 = 32'h100;
    tick();
    chk("pc8", e_pc8, 32'h104);

    stall = 1; reset = 1;
    tick();
    chk("rst_stall_valid", 32'(e_valid), 0);
    chk("rst_stall_jal", 32'(e_jal), 0);
    reset = 0; stall = 0;

    for (int i = 0; i < 60; i++) begin
      rand_id();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 15) == 0);
      tick();
    end
    reset = 0; stall = 0; flush = 0;
    tick();
    @(negedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
